window_conv: RTL and testbench
==============================

# window_conv

Pipelined 2-D convolution stage that sits directly downstream of the video window generator. Each clock it takes `PX_PER_CLK` square pixel windows and multiplies each window by a runtime-loadable signed kernel. It sums the products, then rounds, shifts and clips the result back to `PX_WIDTH`. It emits a pixel stream with the same sideband flags as the input, delayed by a fixed 4 cycles. Kernel updates are double-buffered and take effect only on a frame boundary.

## Interface
- `PX_WIDTH`, 12: unsigned pixel width.
- `PX_PER_CLK`, 4: pixels (windows) per clock.
- `WIN_SIZE`, 3: window side length.
- `COEF_WIDTH`, 8: signed coefficient width.
- `SHIFT`, 4: fixed right shift applied to the sum (0 allowed).

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `win_data_i`  in  `PX_PER_CLK*WIN_SIZE*WIN_SIZE*PX_WIDTH`  windows, packed `[p][y][x][bit]`; centre is `[p][WIN_SIZE/2][WIN_SIZE/2]`.
- `win_data_val_i`  in  `PX_PER_CLK`  per-lane window valid.
- `line_start_i`, `line_end_i`, `frame_start_i`, `frame_end_i`  in  1 each  sideband flags aligned with the window beat.
- `coef_i`  in  `WIN_SIZE*WIN_SIZE*COEF_WIDTH`  kernel, packed `[y][x][bit]`, two's complement.
- `coef_wr_i`  in  1  single-cycle strobe that captures `coef_i` into the shadow set.
- `coef_pending_o`  out  1  shadow set loaded but not yet active.
- `px_data_o`  out  `PX_PER_CLK*PX_WIDTH`  filtered pixels.
- `px_data_val_o`  out  `PX_PER_CLK`  per-lane valid.
- `line_start_o`, `line_end_o`, `frame_start_o`, `frame_end_o`  out  1 each  delayed flags.

## Operation
- **Stage 1 (multiply).**
  - Each pixel is zero-extended to signed `PX_WIDTH+1`.
  - It is multiplied by its coefficient.
  - The product is registered at width `PW = PX_WIDTH+1+COEF_WIDTH`.
- **Stage 2 (row sums).** Per lane, the `WIN_SIZE` products of each row are summed and registered.
- **Stage 3 (total).** The row sums are summed and registered at width `SW = PW + clog2(WIN_SIZE*WIN_SIZE)`. No overflow is possible.
- **Stage 4 (round, shift, clip).**
  - If `SHIFT>0`, add `1<<(SHIFT-1)`.
  - Arithmetic shift right by `SHIFT`.
  - Clip to `[0, 2^PX_WIDTH-1]`.
  - Register the result.
  - Lanes with valid 0 output data 0.
- **Coefficient sets.** There are two sets: shadow and active.
  - `coef_wr_i`=1 writes shadow ← `coef_i` and sets `pending`=1.
  - **Swap.** When `frame_start_i`=1 and `pending`=1, that beat's stage 1 already uses shadow. On the same edge active ← shadow and `pending` ← 0.
  - **Simultaneous write and swap.** If `coef_wr_i` and a swap occur together, the current frame uses the old shadow. The new write lands in shadow and `pending` stays 1.
  - A write while `pending`=1 overwrites shadow; only the last write is applied.
  - A write with no following `frame_start_i` never takes effect.
  - `coef_pending_o` = `pending`.
- **Reset values.**
  - Shadow and active reset to the identity kernel: centre = `1<<SHIFT`, all other taps 0.
  - `pending` resets to 0.
- **Flags.** Flags are never reinterpreted; they pass through the 4-stage delay untouched, even on beats with no valid lane.
- **No backpressure.** Every input beat is accepted.

## Timing
- Latency is exactly 4 cycles for all outputs: an input beat at edge t appears on the outputs after edge t+4.
- Throughput is one beat per clock with no bubbles.
- Sideband and valid are delayed by a 4-deep register chain matched to the data path.
- **Reset.** All outputs are 0 during and after reset: `px_data_o`, `px_data_val_o`, the four flags and `coef_pending_o`. All pipeline contents are cleared.
- **Reset mid-frame.** In-flight beats are discarded, with no partial output. Coefficients return to identity.
- The coefficient swap is evaluated only at the edge where the input carries `frame_start_i`. It is independent of `win_data_val_i`.

## Configuration
- `WINDOW_CONV_ABS_EN`
  - **Defined:** stage 4 takes the absolute value of the total before rounding. This is intended for gradient/Sobel kernels.
  - **Undefined:** negative totals round and shift as signed, then clip to 0.
  - Pipeline depth and latency are identical in both builds.

## Test plan
- **Identity after reset.** Centre = 0x123 on all lanes, all valid, other taps random → `px_data_o` = 0x123 on every lane 4 cycles later; `coef_pending_o`=0.
- **Deferred box kernel.** Write all taps = 1 mid-frame, all pixels = 160 → `coef_pending_o`=1 and the rest of the frame stays identity (160). The next `frame_start_i` beat outputs (1440+8)>>4 = 90 and `pending` clears.
- **Saturation.** Centre tap 127, pixel 4095 → 4095 (clipped from 32504). Centre tap 0 with all others 0 → 0.
- **Negative total.** Centre tap −16, pixel 100 → 0 without `WINDOW_CONV_ABS_EN`; 100 with it.
- **Write coincident with swap.** Kernel A pending; write kernel B on the same cycle as `frame_start_i` → the frame uses A and `coef_pending_o` stays 1. The following frame uses B.
- **Sideband and reset.** `line_end_i` at t → `line_end_o` at t+4. Lane mask 0b0101 → `px_data_val_o` = 0b0101 with lanes 1 and 3 data = 0. Assert `rst_i` mid-line → all outputs 0 immediately; after release, identity behaviour resumes.

Source files
------------

// File: rtl/window_conv_if.sv
// Window-in / pixel-out stream bus of the window_conv stage, plus its kernel load port.
interface window_conv_if #(
  parameter int unsigned PX_WIDTH   = 12,
  parameter int unsigned PX_PER_CLK = 4,
  parameter int unsigned WIN_SIZE   = 3,
  parameter int unsigned COEF_WIDTH = 8
);
  logic [PX_PER_CLK*WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] win_data_i;
  logic [PX_PER_CLK-1:0]                            win_data_val_i;
  logic                                             line_start_i;
  logic                                             line_end_i;
  logic                                             frame_start_i;
  logic                                             frame_end_i;
  logic [WIN_SIZE*WIN_SIZE*COEF_WIDTH-1:0]          coef_i;
  logic                                             coef_wr_i;
  logic                                             coef_pending_o;
  logic [PX_PER_CLK*PX_WIDTH-1:0]                   px_data_o;
  logic [PX_PER_CLK-1:0]                            px_data_val_o;
  logic                                             line_start_o;
  logic                                             line_end_o;
  logic                                             frame_start_o;
  logic                                             frame_end_o;

  modport slave (
    input  win_data_i, win_data_val_i, line_start_i, line_end_i, frame_start_i, frame_end_i,
    input  coef_i, coef_wr_i,
    output coef_pending_o, px_data_o, px_data_val_o,
    output line_start_o, line_end_o, frame_start_o, frame_end_o
  );

  modport master (
    output win_data_i, win_data_val_i, line_start_i, line_end_i, frame_start_i, frame_end_i,
    output coef_i, coef_wr_i,
    input  coef_pending_o, px_data_o, px_data_val_o,
    input  line_start_o, line_end_o, frame_start_o, frame_end_o
  );
endinterface

// File: rtl/window_conv.sv
// 4-stage 2-D convolution of PX_PER_CLK windows with a frame-synchronous double-buffered kernel.
// Define WINDOW_CONV_ABS_EN to take |total| before rounding (gradient/Sobel kernels).
module window_conv #(
  parameter int unsigned PX_WIDTH   = 12,
  parameter int unsigned PX_PER_CLK = 4,
  parameter int unsigned WIN_SIZE   = 3,
  parameter int unsigned COEF_WIDTH = 8,
  parameter int unsigned SHIFT      = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  window_conv_if.slave bus
);
  localparam int unsigned NTAP  = WIN_SIZE * WIN_SIZE;
  localparam int unsigned PW    = PX_WIDTH + 1 + COEF_WIDTH;
  localparam int unsigned SW    = PW + $clog2(NTAP);
  localparam int unsigned AW    = SW + 1;
  localparam int unsigned KW    = NTAP * COEF_WIDTH;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CTR   = (WIN_SIZE / 2) * WIN_SIZE + WIN_SIZE / 2;
  localparam int unsigned RND   = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;
  localparam logic [PX_WIDTH-1:0] PX_MAX  = '1;
  localparam logic [KW-1:0]       IDENT_K = KW'(COEF_WIDTH'(1 << SHIFT)) << (CTR * COEF_WIDTH);

  logic [KW-1:0]                  r_coef_shadow;
  logic [KW-1:0]                  r_coef_active;
  logic                           r_pending;
  logic                           w_swap;
  logic [KW-1:0]                  w_coef;
  logic signed [PW-1:0]           r_prod [PX_PER_CLK][NTAP];
  logic signed [SW-1:0]           w_row  [PX_PER_CLK][WIN_SIZE];
  logic signed [SW-1:0]           r_row  [PX_PER_CLK][WIN_SIZE];
  logic signed [SW-1:0]           w_sum  [PX_PER_CLK];
  logic signed [SW-1:0]           r_sum  [PX_PER_CLK];
  logic signed [AW-1:0]           w_tot;
  logic signed [AW-1:0]           w_rnd;
  logic signed [AW-1:0]           w_sh;
  logic [PX_PER_CLK*PX_WIDTH-1:0] w_px;
  logic [PX_PER_CLK*PX_WIDTH-1:0] r_px;
  logic [PX_PER_CLK-1:0]          r_val  [DEPTH];
  logic [3:0]                     r_flag [DEPTH];

  // A pending set is used by the frame_start beat itself, so stage 1 selects it combinationally.
  assign w_swap = bus.frame_start_i & r_pending;
  assign w_coef = w_swap ? r_coef_shadow : r_coef_active;

  always_ff @(posedge clk_i or posedge rst_i) begin : p_coef
    if (rst_i) begin
      r_coef_shadow <= IDENT_K;
      r_coef_active <= IDENT_K;
      r_pending     <= 1'b0;
    end else begin
      if (w_swap) r_coef_active <= r_coef_shadow;
      if (bus.coef_wr_i) r_coef_shadow <= bus.coef_i;
      if (bus.coef_wr_i)  r_pending <= 1'b1;
      else if (w_swap)    r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : p_mul
    if (rst_i) begin
      r_prod <= '{default: '0};
    end else begin
      for (int unsigned p = 0; p < PX_PER_CLK; p++) begin
        for (int unsigned t = 0; t < NTAP; t++) begin
          r_prod[p][t] <= PW'($signed({1'b0, bus.win_data_i[(p*NTAP+t)*PX_WIDTH +: PX_WIDTH]}))
                        * PW'($signed(w_coef[t*COEF_WIDTH +: COEF_WIDTH]));
        end
      end
    end
  end

  always_comb begin : p_adders
    w_row = '{default: '0};
    w_sum = '{default: '0};
    for (int unsigned p = 0; p < PX_PER_CLK; p++) begin
      for (int unsigned y = 0; y < WIN_SIZE; y++) begin
        for (int unsigned x = 0; x < WIN_SIZE; x++) begin
          w_row[p][y] = w_row[p][y] + SW'(r_prod[p][y*WIN_SIZE+x]);
        end
        w_sum[p] = w_sum[p] + r_row[p][y];
      end
    end
  end

  // Round half-up, arithmetic shift, clip to the pixel range; invalid lanes forced to 0.
  always_comb begin : p_round
    w_px  = '0;
    w_tot = '0;
    w_rnd = '0;
    w_sh  = '0;
    for (int unsigned p = 0; p < PX_PER_CLK; p++) begin
      w_tot = AW'(r_sum[p]);
`ifdef WINDOW_CONV_ABS_EN
      if (w_tot < 0) w_tot = -w_tot;
`else
      w_tot = w_tot;
`endif
      w_rnd = w_tot + $signed(AW'(RND));
      w_sh  = w_rnd >>> SHIFT;
      if (!r_val[2][p] || w_sh < 0) begin
        w_px[p*PX_WIDTH +: PX_WIDTH] = '0;
      end else if (w_sh > $signed(AW'(PX_MAX))) begin
        w_px[p*PX_WIDTH +: PX_WIDTH] = PX_MAX;
      end else begin
        w_px[p*PX_WIDTH +: PX_WIDTH] = PX_WIDTH'(w_sh);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : p_pipe
    if (rst_i) begin
      r_row  <= '{default: '0};
      r_sum  <= '{default: '0};
      r_px   <= '0;
      r_val  <= '{default: '0};
      r_flag <= '{default: '0};
    end else begin
      r_row     <= w_row;
      r_sum     <= w_sum;
      r_px      <= w_px;
      r_val[0]  <= bus.win_data_val_i;
      r_flag[0] <= {bus.frame_end_i, bus.frame_start_i, bus.line_end_i, bus.line_start_i};
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_val[s]  <= r_val[s-1];
        r_flag[s] <= r_flag[s-1];
      end
    end
  end

  assign bus.coef_pending_o = r_pending;
  assign bus.px_data_o      = r_px;
  assign bus.px_data_val_o  = r_val[DEPTH-1];
  assign bus.line_start_o   = r_flag[DEPTH-1][0];
  assign bus.line_end_o     = r_flag[DEPTH-1][1];
  assign bus.frame_start_o  = r_flag[DEPTH-1][2];
  assign bus.frame_end_o    = r_flag[DEPTH-1][3];
endmodule

// File: tb/tb_window_conv.sv
// Directed bench for window_conv: behavioural kernel/pixel model feeding an expected-output queue.
module tb_window_conv;
  localparam int unsigned PXW = 12;
  localparam int unsigned NP  = 4;
  localparam int unsigned WS  = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned SH  = 4;
  localparam int unsigned NT  = WS * WS;
  localparam int unsigned LW  = NT * PXW;
  localparam int unsigned WW  = NP * LW;
  localparam int unsigned KW  = NT * CW;
  localparam int unsigned CTR = (WS / 2) * WS + WS / 2;

  typedef struct {
    int unsigned          due;
    logic [NP*PXW-1:0]    data;
    logic [NP-1:0]        val;
    logic [3:0]           flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        q[$];
  exp_t        m_e;
  logic [KW-1:0] m_shadow, m_active, k_ident, k_a, k_b;
  logic          m_pending;

  window_conv_if #(.PX_WIDTH(PXW), .PX_PER_CLK(NP), .WIN_SIZE(WS), .COEF_WIDTH(CW)) bus ();

  window_conv #(.PX_WIDTH(PXW), .PX_PER_CLK(NP), .WIN_SIZE(WS), .COEF_WIDTH(CW), .SHIFT(SH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PXW-1:0] model_px(input logic [LW-1:0] w, input logic [KW-1:0] k);
    int acc = 0;
    for (int t = 0; t < NT; t++) acc += int'(w[t*PXW +: PXW]) * int'($signed(k[t*CW +: CW]));
`ifdef WINDOW_CONV_ABS_EN
    if (acc < 0) acc = -acc;
`endif
    if (SH > 0) acc += 1 << (SH - 1);
    acc = acc >>> SH;
    if (acc < 0) return '0;
    if (acc > (1 << PXW) - 1) return '1;
    return PXW'(acc);
  endfunction

  function automatic logic [WW-1:0] win_centre(input logic [PXW-1:0] c);
    logic [WW-1:0] w;
    for (int p = 0; p < NP; p++)
      for (int t = 0; t < NT; t++) w[(p*NT+t)*PXW +: PXW] = (t == CTR) ? c : PXW'($urandom);
    return w;
  endfunction

  function automatic logic [WW-1:0] win_fill(input logic [PXW-1:0] v);
    logic [WW-1:0] w;
    for (int i = 0; i < NP * NT; i++) w[i*PXW +: PXW] = v;
    return w;
  endfunction

  function automatic logic [WW-1:0] win_rand();
    logic [WW-1:0] w;
    for (int i = 0; i < NP * NT; i++) w[i*PXW +: PXW] = PXW'($urandom);
    return w;
  endfunction

  function automatic logic [KW-1:0] kern_centre(input logic [CW-1:0] c);
    logic [KW-1:0] k = '0;
    k[CTR*CW +: CW] = c;
    return k;
  endfunction

  function automatic logic [KW-1:0] kern_fill(input logic [CW-1:0] v);
    logic [KW-1:0] k;
    for (int t = 0; t < NT; t++) k[t*CW +: CW] = v;
    return k;
  endfunction

  function automatic logic [KW-1:0] kern_rand();
    logic [KW-1:0] k;
    for (int t = 0; t < NT; t++) k[t*CW +: CW] = CW'($urandom_range(0, 40)) - 8'd12;
    return k;
  endfunction

  task automatic clear_inputs();
    bus.win_data_i     = '0;
    bus.win_data_val_i = '0;
    bus.line_start_i   = 1'b0;
    bus.line_end_i     = 1'b0;
    bus.frame_start_i  = 1'b0;
    bus.frame_end_i    = 1'b0;
    bus.coef_i         = '0;
    bus.coef_wr_i      = 1'b0;
  endtask

  task automatic model_reset();
    m_shadow  = k_ident;
    m_active  = k_ident;
    m_pending = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    logic [56:0] obs;
    obs = {bus.px_data_o, bus.px_data_val_o, bus.line_start_o, bus.line_end_o,
           bus.frame_start_o, bus.frame_end_o, bus.coef_pending_o};
    vectors++;
    assert (obs === 57'd0) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected 0", tag, obs);
    end
  endtask

  // flags = {frame_end, frame_start, line_end, line_start}
  task automatic beat(input logic [WW-1:0] win, input logic [NP-1:0] val, input logic [3:0] flags,
                      input logic wr, input logic [KW-1:0] k);
    exp_t          e;
    logic          swap;
    logic [KW-1:0] use_k;
    @(negedge clk);
    vectors++;
    assert (bus.coef_pending_o === m_pending) else begin
      miscompares++;
      $error("FAIL coef_pending: observed %b expected %b", bus.coef_pending_o, m_pending);
    end
    bus.win_data_i     = win;
    bus.win_data_val_i = val;
    bus.line_start_i   = flags[0];
    bus.line_end_i     = flags[1];
    bus.frame_start_i  = flags[2];
    bus.frame_end_i    = flags[3];
    bus.coef_i         = k;
    bus.coef_wr_i      = wr;
    swap  = flags[2] && m_pending;
    use_k = swap ? m_shadow : m_active;
    e.due   = cyc + 4;
    e.val   = val;
    e.flags = flags;
    e.data  = '0;
    for (int p = 0; p < NP; p++)
      if (val[p]) e.data[p*PXW +: PXW] = model_px(win[p*LW +: LW], use_k);
    q.push_back(e);
    if (swap) m_active = m_shadow;
    if (wr) begin
      m_shadow  = k;
      m_pending = 1'b1;
    end else if (swap) begin
      m_pending = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      m_e = q.pop_front();
      vectors += 3;
      assert (bus.px_data_o === m_e.data) else begin
        miscompares++;
        $error("FAIL px_data @%0d: observed %h expected %h", cyc, bus.px_data_o, m_e.data);
      end
      assert (bus.px_data_val_o === m_e.val) else begin
        miscompares++;
        $error("FAIL px_data_val @%0d: observed %b expected %b", cyc, bus.px_data_val_o, m_e.val);
      end
      assert ({bus.frame_end_o, bus.frame_start_o, bus.line_end_o, bus.line_start_o} === m_e.flags) else begin
        miscompares++;
        $error("FAIL flags @%0d: observed %b expected %b", cyc,
               {bus.frame_end_o, bus.frame_start_o, bus.line_end_o, bus.line_start_o}, m_e.flags);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    k_ident = kern_centre(CW'(1 << SH));
    model_reset();
    #1 check_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // identity kernel out of reset
    beat(win_centre(12'h123), 4'hF, 4'b0101, 1'b0, '0);
    beat(win_centre(12'h123), 4'hF, 4'b0000, 1'b0, '0);
    beat(win_centre(12'h123), 4'hF, 4'b0010, 1'b0, '0);

    // box kernel written mid-frame, active from the next frame_start
    beat(win_fill(12'd160), 4'hF, 4'b0000, 1'b1, kern_fill(8'd1));
    beat(win_fill(12'd160), 4'hF, 4'b0000, 1'b0, '0);
    beat(win_fill(12'd160), 4'hF, 4'b1010, 1'b0, '0);
    beat(win_fill(12'd160), 4'hF, 4'b0101, 1'b0, '0);
    beat(win_fill(12'd160), 4'hF, 4'b0000, 1'b0, '0);

    // saturation high, then all-zero kernel
    beat(win_fill(12'd4095), 4'hF, 4'b0000, 1'b1, kern_centre(8'd127));
    beat(win_fill(12'd4095), 4'hF, 4'b0100, 1'b0, '0);
    beat(win_fill(12'd4095), 4'hF, 4'b0000, 1'b1, '0);
    beat(win_rand(),         4'hF, 4'b0100, 1'b0, '0);

    // negative total (centre -16)
    beat(win_fill(12'd100), 4'hF, 4'b0000, 1'b1, kern_centre(8'hF0));
    beat(win_fill(12'd100), 4'hF, 4'b0100, 1'b0, '0);

    // write coincident with swap
    k_a = kern_rand();
    k_b = kern_rand();
    beat(win_rand(), 4'hF, 4'b0000, 1'b1, k_a);
    beat(win_rand(), 4'hF, 4'b0100, 1'b1, k_b);
    beat(win_rand(), 4'hF, 4'b0000, 1'b0, '0);
    beat(win_rand(), 4'hF, 4'b0100, 1'b0, '0);
    beat(win_rand(), 4'hF, 4'b0000, 1'b0, '0);

    // lane masks and flags on beats without valid lanes
    beat(win_rand(), 4'b0101, 4'b0010, 1'b0, '0);
    beat(win_rand(), 4'b0000, 4'b1000, 1'b0, '0);
    beat(win_rand(), 4'b1010, 4'b0001, 1'b0, '0);

    for (int i = 0; i < 12; i++)
      beat(win_rand(), 4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, kern_rand());

    // reset in the middle of a line
    beat(win_centre(12'h321), 4'hF, 4'b0001, 1'b0, '0);
    beat(win_rand(), 4'hF, 4'b0000, 1'b1, kern_fill(8'd2));
    @(negedge clk);
    #2 rst = 1'b1;
    clear_inputs();
    #1 check_zero("reset_midline");
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    beat(win_centre(12'h0AB), 4'hF, 4'b0101, 1'b0, '0);
    beat(win_centre(12'hFFF), 4'hF, 4'b0000, 1'b0, '0);

    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 8; i++) if (q.size() > 0) @(negedge clk);
    vectors++;
    assert (q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: observed %0d outstanding expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
